// File: rtl/hlsm_job_sequencer_if.sv
// hlsm_job_sequencer_if
//   Bundles the three streams around the HLSM job sequencer:
//     - operand stream   : in_valid / in_ready / in_a / in_b / in_c
//     - core launch port : hlsm_start / hlsm_done / hlsm_a..c / hlsm_z / hlsm_x
//     - result stream    : out_valid / out_ready / out_z / out_x / out_err
//   master : the sequencer's view (drives in_ready, hlsm_*, out_*)
//   slave  : the environment's view (upstream source, core, downstream sink)
//
// Handshake rule for both streams: a transfer happens on a rising Clk edge
// where valid and ready are both high. Once the sequencer raises out_valid,
// it holds out_valid and the result fields stable until that transfer.
interface hlsm_job_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] in_c;

  logic              hlsm_start;
  logic              hlsm_done;
  logic [DATA_W-1:0] hlsm_a;
  logic [DATA_W-1:0] hlsm_b;
  logic [DATA_W-1:0] hlsm_c;
  logic [DATA_W-1:0] hlsm_z;
  logic [DATA_W-1:0] hlsm_x;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_z;
  logic [DATA_W-1:0] out_x;
  logic              out_err;

  modport master (
    input  in_valid, in_a, in_b, in_c,
    output in_ready,
    output hlsm_start, hlsm_a, hlsm_b, hlsm_c,
    input  hlsm_done, hlsm_z, hlsm_x,
    output out_valid, out_z, out_x, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_a, in_b, in_c,
    input  in_ready,
    input  hlsm_start, hlsm_a, hlsm_b, hlsm_c,
    output hlsm_done, hlsm_z, hlsm_x,
    input  out_valid, out_z, out_x, out_err,
    output out_ready
  );
endinterface

// File: rtl/hlsm_job_sequencer.sv
// hlsm_job_sequencer
//   Wraps the generated HLSM datapath core. Accepts one operand triple,
//   holds it stable on hlsm_a/b/c, pulses hlsm_start for one cycle, waits
//   for hlsm_done, captures hlsm_z/hlsm_x and offers them on the result
//   stream. Only one job is in flight at a time.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous, active-high reset
//   bus        hlsm_job_sequencer_if.master (operand, core and result ports)
//   busy       high whenever the FSM is not IDLE
//   job_count  completed jobs (timeouts included), wraps at 2^CNT_W
//   dbg_state  current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT, 3 HOLD)
//
// Optional feature macro: HLSM_SEQ_TIMEOUT_EN
//   Defined   : WAIT aborts after TIMEOUT_CYC cycles without hlsm_done and
//               returns out_err=1 with zero results.
//   Undefined : WAIT waits forever, out_err is always 0.
module hlsm_job_sequencer #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  hlsm_job_sequencer_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] job_count,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("hlsm_job_sequencer: TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]        state;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0] z_q, x_q;
  logic              err_q;
  logic              tmo_hit;

`ifdef HLSM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Cleared in LAUNCH so every WAIT starts from zero. It counts WAIT cycles
  // without Done; the cycle where it already holds TIMEOUT_CYC-1 is the
  // TIMEOUT_CYC-th such cycle, which is where the abort fires.
  always_ff @(posedge Clk) begin
    if (Rst || state == S_LAUNCH) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT && !bus.hlsm_done) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      z_q       <= '0;
      x_q       <= '0;
      err_q     <= 1'b0;
      job_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is high in IDLE, so in_valid alone completes the transfer.
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            c_q   <= bus.in_c;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over a timeout landing on the same cycle.
          if (bus.hlsm_done) begin
            z_q       <= bus.hlsm_z;
            x_q       <= bus.hlsm_x;
            err_q     <= 1'b0;
            job_count <= job_count + 1'b1;
            state     <= S_HOLD;
          end else if (tmo_hit) begin
            z_q       <= '0;
            x_q       <= '0;
            err_q     <= 1'b1;
            job_count <= job_count + 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Always pass through IDLE, so a triple waiting here is taken
          // no earlier than the IDLE cycle that follows.
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.hlsm_start = (state == S_LAUNCH);
  assign bus.hlsm_a     = a_q;
  assign bus.hlsm_b     = b_q;
  assign bus.hlsm_c     = c_q;
  assign bus.out_valid  = (state == S_HOLD);
  assign bus.out_z      = z_q;
  assign bus.out_x      = x_q;
  assign bus.out_err    = err_q;
  assign busy           = (state != S_IDLE);
  assign dbg_state      = state;

endmodule
